// File: rtl/uart_fifo_bridge.sv
// CPU <-> UART byte bridge: independent first-word-fall-through TX and RX FIFOs.
// Latency: a pushed byte reaches the FIFO head one cycle after its push edge.
// Backpressure: ready = FIFO not full. A full TX FIFO refuses writes. A full RX FIFO drops the byte and sets sticky rx_overflow.
// Optional occupancy and drop-count outputs exist only when UART_FIFO_STATUS_EN is defined.

module uart_fifo_bridge_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    output logic                     push_rdy,
    output logic                     pop_vld,
    output logic [WIDTH-1:0]         pop_dat,
    input  logic                     pop_rdy
`ifdef UART_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]   count
`endif
);
    localparam int AW = $clog2(DEPTH);

    // The pointer MSB acts as a wrap bit. It separates the full state from the empty state when the addresses are equal.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_rdy = !full;
    assign pop_vld  = !empty;
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;
    assign pop_dat  = mem[rd_ptr[AW-1:0]];

`ifdef UART_FIFO_STATUS_EN
    assign count = wr_ptr - rd_ptr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset. The reset pointers make stale entries invisible.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end
endmodule

module uart_fifo_bridge #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         DataIn,
    input  logic                     DataInValid,
    output logic                     DataInReady,
    output logic [WIDTH-1:0]         DataOut,
    output logic                     DataOutValid,
    input  logic                     DataOutReady,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     rx_overflow
`ifdef UART_FIFO_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic [7:0]               rx_drop_cnt
`endif
);
    logic rx_drop;

    uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) tx_fifo (
        .clk      (CLK),
        .reset    (reset),
        .push_vld (DataInValid),
        .push_dat (DataIn),
        .push_rdy (DataInReady),
        .pop_vld  (tx_valid),
        .pop_dat  (tx_data),
        .pop_rdy  (tx_ready)
`ifdef UART_FIFO_STATUS_EN
        ,
        .count    (tx_count)
`endif
    );

    uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) rx_fifo (
        .clk      (CLK),
        .reset    (reset),
        .push_vld (rx_valid),
        .push_dat (rx_data),
        .push_rdy (rx_ready),
        .pop_vld  (DataOutValid),
        .pop_dat  (DataOut),
        .pop_rdy  (DataOutReady)
`ifdef UART_FIFO_STATUS_EN
        ,
        .count    (rx_count)
`endif
    );

    // The UART receiver cannot be stalled, so a byte that arrives while the RX FIFO is full is lost.
    assign rx_drop = rx_valid && !rx_ready;

    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_overflow <= 1'b0;
        end else if (rx_drop) begin
            rx_overflow <= 1'b1;
        end
    end

`ifdef UART_FIFO_STATUS_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            rx_drop_cnt <= '0;
        end else if (rx_drop && (rx_drop_cnt != 8'hFF)) begin
            rx_drop_cnt <= rx_drop_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge. A queue model checks the flags every cycle and checks the data at each pop.
module tb_uart_fifo_bridge;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] DataIn = '0;
    logic             DataInValid = 1'b0;
    logic             DataInReady;
    logic [WIDTH-1:0] DataOut;
    logic             DataOutValid;
    logic             DataOutReady = 1'b0;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [WIDTH-1:0] rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic             rx_overflow;
`ifdef UART_FIFO_STATUS_EN
    logic [CW-1:0]    tx_count;
    logic [CW-1:0]    rx_count;
    logic [7:0]       rx_drop_cnt;
`endif

    uart_fifo_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .DataIn       (DataIn),
        .DataInValid  (DataInValid),
        .DataInReady  (DataInReady),
        .DataOut      (DataOut),
        .DataOutValid (DataOutValid),
        .DataOutReady (DataOutReady),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_overflow  (rx_overflow)
`ifdef UART_FIFO_STATUS_EN
        ,
        .tx_count     (tx_count),
        .rx_count     (rx_count),
        .rx_drop_cnt  (rx_drop_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int               checks = 0;
    int               failures = 0;
    logic [WIDTH-1:0] tx_q[$];
    logic [WIDTH-1:0] rx_q[$];
    logic [WIDTH-1:0] tx_out[$];
    logic [WIDTH-1:0] rx_out[$];
    bit               m_ovf = 1'b0;
    int               m_drop = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s disagrees with model", tag);
        end
    endtask

    // Compare the outputs against the model, advance one clock edge, then update the model.
    task automatic step();
        bit               tx_push, tx_pop, rx_push, rx_pop, drop, rst;
        logic [WIDTH-1:0] din, rin;
        check("DataInReady", DataInReady, 32'(tx_q.size() < DEPTH));
        check("tx_valid", tx_valid, 32'(tx_q.size() != 0));
        check("rx_ready", rx_ready, 32'(rx_q.size() < DEPTH));
        check("DataOutValid", DataOutValid, 32'(rx_q.size() != 0));
        check("rx_overflow", rx_overflow, 32'(m_ovf));
`ifdef UART_FIFO_STATUS_EN
        check("tx_count", tx_count, tx_q.size());
        check("rx_count", rx_count, rx_q.size());
        check("rx_drop_cnt", rx_drop_cnt, m_drop);
`endif
        tx_pop  = tx_ready && (tx_q.size() != 0);
        rx_pop  = DataOutReady && (rx_q.size() != 0);
        tx_push = DataInValid && (tx_q.size() < DEPTH);
        rx_push = rx_valid && (rx_q.size() < DEPTH);
        drop    = rx_valid && !(rx_q.size() < DEPTH);
        rst     = reset;
        din     = DataIn;
        rin     = rx_data;
        if (tx_pop) check("tx_data", tx_data, tx_q[0]);
        if (rx_pop) check("DataOut", DataOut, rx_q[0]);
        @(posedge CLK);
        #1;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (tx_pop) tx_out.push_back(tx_q.pop_front());
            if (rx_pop) rx_out.push_back(rx_q.pop_front());
            if (tx_push) tx_q.push_back(din);
            if (rx_push) rx_q.push_back(rin);
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        logic [WIDTH-1:0] exp4 [7];
        exp4 = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2, 8'hB3};

        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        step();

        // Two writes stream straight through to the transmitter.
        tx_out.delete();
        tx_ready = 1'b1;
        DataInValid = 1'b1; DataIn = 8'h41; step();
        DataIn = 8'h42; step();
        DataInValid = 1'b0;
        run(3);
        check("s1_len", tx_out.size(), 2);
        check("s1_b0", tx_out[0], 8'h41);
        check("s1_b1", tx_out[1], 8'h42);

        // Fill the TX FIFO while the transmitter stalls. The extra write of 0xFF must be refused.
        tx_out.delete();
        tx_ready = 1'b0;
        DataInValid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            DataIn = WIDTH'(i);
            step();
        end
        DataIn = 8'hFF; step();
        DataInValid = 1'b0;
        tx_ready = 1'b1;
        run(DEPTH + 2);
        check("s2_len", tx_out.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("s2_order", tx_out[i], i);

        // Overrun the RX FIFO by one byte.
        rx_out.delete();
        rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 8'h10 + WIDTH'(i);
            step();
        end
        rx_data = 8'h99; step();
        rx_valid = 1'b0;
        step();
        check("s3_ovf_sticky", rx_overflow, 1);
        DataOutReady = 1'b1;
        run(DEPTH + 2);
        DataOutReady = 1'b0;
        check("s3_len", rx_out.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("s3_order", rx_out[i], 8'h10 + i);

        // Push and pop at the same time on a partly filled TX FIFO.
        tx_out.delete();
        tx_ready = 1'b0;
        DataInValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DataIn = 8'hA0 + WIDTH'(i);
            step();
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DataIn = 8'hB0 + WIDTH'(i);
            step();
            check("s4_occ_model", tx_q.size(), 3);
        end
        DataInValid = 1'b0;
        run(5);
        check("s4_len", tx_out.size(), 7);
        for (int i = 0; i < 7; i++) check("s4_order", tx_out[i], exp4[i]);

        // Reset in the middle of traffic. The handshakes in the reset cycle are ignored.
        tx_ready = 1'b0;
        DataInValid = 1'b1;
        rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DataIn = 8'hC0 + WIDTH'(i);
            rx_data = 8'hD0 + WIDTH'(i);
            if (i == 2) rx_valid = 1'b0;
            step();
        end
        check("s5_tx_held", tx_valid, 1);
        check("s5_rx_held", DataOutValid, 1);
        reset = 1'b1; rx_valid = 1'b1; tx_ready = 1'b1; DataOutReady = 1'b1;
        step();
        reset = 1'b0; DataInValid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0; DataOutReady = 1'b0;
        step();
        check("s5_txv", tx_valid, 0);
        check("s5_rxv", DataOutValid, 0);
        check("s5_ovf", rx_overflow, 0);

        // Stream several laps of pointer wrap through RX, then fill and overrun the FIFO at the wrapped offset.
        rx_out.delete();
        DataOutReady = 1'b1;
        rx_valid = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            rx_data = WIDTH'(i + 3);
            step();
        end
        rx_valid = 1'b0;
        run(2);
        check("s6_len", rx_out.size(), 3 * DEPTH);
        for (int i = 0; i < 3 * DEPTH; i++) check("s6_order", rx_out[i], i + 3);
        rx_out.delete();
        DataOutReady = 1'b0;
        rx_valid = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            rx_data = 8'hE0 + WIDTH'(i);
            step();
        end
        rx_valid = 1'b0;
        step();
        check("s6_full", rx_ready, 0);
        DataOutReady = 1'b1;
        run(DEPTH + 2);
        check("s6_len2", rx_out.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("s6_order2", rx_out[i], 8'hE0 + i);
        check("s6_empty", DataOutValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_fifo_bridge.md
UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per FIFO; a power of two, 2..256.
REQ-002 SHALL have parameter WIDTH, default 8, bits per entry.
REQ-003 SHALL have CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have DataIn  input  WIDTH  CPU byte to transmit.
REQ-006 SHALL have DataInValid  input  1  CPU one-cycle write strobe.
REQ-007 SHALL have DataInReady  output  1  TX FIFO not full.
REQ-008 SHALL have DataOut  output  WIDTH  RX FIFO head byte.
REQ-009 SHALL have DataOutValid  output  1  RX FIFO not empty.
REQ-010 SHALL have DataOutReady  input  1  CPU one-cycle read strobe; pops the head.
REQ-011 SHALL have tx_data  output  WIDTH  byte to the UART transmitter.
REQ-012 SHALL have tx_valid  output  1  TX FIFO not empty.
REQ-013 SHALL have tx_ready  input  1  UART transmitter accepts tx_data.
REQ-014 SHALL have rx_data  input  WIDTH  byte from the UART receiver.
REQ-015 SHALL have rx_valid  input  1  rx_data is valid.
REQ-016 SHALL have rx_ready  output  1  RX FIFO not full.
REQ-017 SHALL have rx_overflow  output  1  sticky flag: a received byte was dropped.

Function
REQ-018 SHALL contain two independent FIFOs: TX (CPU to UART) and RX (UART to CPU).
REQ-019 Each FIFO SHALL use read and write pointers of log2(DEPTH)+1 bits.
- Pointers wrap modulo 2*DEPTH.
- Empty when the pointers are equal.
- Full when the addresses match and the MSBs differ.
REQ-020 A push SHALL occur when valid && ready; a pop SHALL occur when the consumer handshake completes (DataOutReady && DataOutValid, or tx_ready && tx_valid).
REQ-021 The outputs SHALL be first-word-fall-through: the head entry drives DataOut/tx_data whenever the FIFO is non-empty.
REQ-022 A pushed entry SHALL appear at the FIFO output on the cycle after the push edge (1-cycle latency).
REQ-023 DataInReady, DataOutValid, tx_valid and rx_ready SHALL be functions of registered pointer state only, with no combinational path from any input.
REQ-024 When a FIFO is full, a push in the same cycle as a pop SHALL be refused, because ready=0; the pop SHALL proceed.
REQ-025 When a FIFO is non-full and non-empty, a simultaneous push and pop SHALL both occur, leaving the count unchanged.
REQ-026 When a FIFO is empty, a pop request SHALL be ignored; a simultaneous push SHALL proceed.
REQ-027 rx_valid asserted while the RX FIFO is full SHALL drop the byte, leave the FIFO unchanged, and set rx_overflow on the next edge.
REQ-028 rx_overflow SHALL remain set until reset.
REQ-029 DataInValid asserted while the TX FIFO is full SHALL be ignored, with no state change.
REQ-030 Storage contents SHALL NOT be reset; only pointers and flags are reset.
REQ-031 Over- and under-run SHALL never corrupt pointers: the count stays within 0..DEPTH.

Reset
REQ-032 While reset is high at a CLK edge, the following SHALL be zeroed:
- all pointers;
- rx_overflow;
- any counters from REQ-034.
REQ-033 After reset the outputs SHALL be:
- DataInReady=1, rx_ready=1;
- DataOutValid=0, tx_valid=0, rx_overflow=0.
A reset asserted mid-traffic SHALL discard all queued bytes, and any handshake in that cycle SHALL be ignored.

Configuration
REQ-034 Macro UART_FIFO_STATUS_EN:
- When defined, the block SHALL add outputs tx_count and rx_count, each log2(DEPTH)+1 bits, giving current occupancy registered with the pointers.
- When defined, the block SHALL add output rx_drop_cnt, 8 bits, counting dropped RX bytes and saturating at 255.
- When undefined, these ports and registers SHALL be absent, with all other behaviour identical.

Verification
REQ-035 Reset, then write 0x41, 0x42 with DataInValid pulses, tx_ready=1 -> tx_data shows 0x41 then 0x42, one per cycle, each one cycle after its push; tx_valid then drops to 0.
REQ-036 tx_ready=0, write 8 bytes 0x00..0x07 -> DataInReady=0 after the 8th; a 9th write of 0xFF is ignored; after tx_ready=1, the output order is 0x00..0x07 with no 0xFF.
REQ-037 Push 8 RX bytes with no CPU read, then a 9th byte 0x99 -> rx_ready=0, rx_overflow=1, rx_drop_cnt=1 (macro on); the reads return the first 8 bytes only.
REQ-038 TX FIFO holding 3 entries, DataInValid and tx_ready both high for 4 cycles -> occupancy stays 3 and the order is preserved.
REQ-039 TX holding 5 bytes and RX holding 2 bytes, assert reset for one cycle -> next cycle DataOutValid=0, tx_valid=0, DataInReady=1, rx_ready=1, rx_overflow=0.
REQ-040 Pointer wrap: stream 3*DEPTH bytes through RX with continuous DataOutReady -> every byte is received in order and the flags toggle correctly at each wrap.
